// File: rtl/memory_stage_pkg.sv
// Shared opcode-class and access-size definitions for the MEM stage and
// anything else that builds byte-lane writes (e.g. a future cache).
package memory_stage_pkg;

  localparam logic [2:0] LOAD_CLASS  = 3'b100;
  localparam logic [2:0] STORE_CLASS = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  // Merge the selected byte lanes of new_data over old_word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/memory_stage_store_lane_gen.sv
// Turns a store size, byte offset and store data into byte enables and
// lane-replicated write data for a word-organised memory.
module store_lane_gen
  import memory_stage_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] rt,
  output logic [3:0]  be,
  output logic [31:0] data
);

  always_comb begin
    be   = 4'b0000;
    data = rt;
    case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << off;
        data = {4{rt[7:0]}};
      end
      SZ_HALF: begin
        be   = 4'b0011 << off;
        data = {2{rt[15:0]}};
      end
      SZ_WORD: begin
        be   = 4'b1111;
        data = rt;
      end
      default: begin
        be   = 4'b0000;
        data = rt;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: byte-enable stores into a word memory, right-aligned
// loads, and the MEM/WB register feeding Inst/PC/AO/MO/fault to WB.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter bit TRACE      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  output logic [31:0] Inst_W,
  output logic [31:0] PC_W,
  output logic [31:0] AO_W,
  output logic [31:0] MO_W,
  output logic        fault_W
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic                  is_load;
  logic                  is_store;
  size_e                 size;
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;
  logic                  misaligned;
  logic                  fault;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic [31:0]           merged;
  logic [31:0]           mo_next;

  logic [31:0] inst_p1;
  logic [31:0] pc_p1;
  logic [31:0] ao_p1;
  logic [31:0] mo_p1;
  logic        fault_p1;

  assign is_load  = (Inst_M[31:29] == LOAD_CLASS);
  assign is_store = (Inst_M[31:29] == STORE_CLASS);
  assign size     = size_e'(Inst_M[27:26]);
  assign off      = AO_M[1:0];
  assign widx     = AO_M[ADDR_WIDTH+1:2];
  assign in_range = (AO_M[31:ADDR_WIDTH+2] == '0);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign fault = (is_load | is_store) & (misaligned | ~in_range);
  assign we    = is_store & ~fault & ~reset;

  store_lane_gen u_lane (
    .size (size),
    .off  (off),
    .rt   (RT_M),
    .be   (be),
    .data (wdata)
  );

  // Combinational read sees any store committed at the previous edge.
  assign rdata   = mem[widx];
  assign merged  = lane_merge(rdata, wdata, be);
  assign mo_next = (is_load & ~fault) ? (rdata >> {off, 3'b000}) : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_p1  <= 32'h0;
      pc_p1    <= 32'h0;
      ao_p1    <= 32'h0;
      mo_p1    <= 32'h0;
      fault_p1 <= 1'b0;
    end else begin
      inst_p1  <= Inst_M;
      pc_p1    <= PC_M;
      ao_p1    <= AO_M;
      mo_p1    <= mo_next;
      fault_p1 <= fault;
    end
  end

  assign Inst_W  = inst_p1;
  assign PC_W    = pc_p1;
  assign AO_W    = ao_p1;
  assign MO_W    = mo_p1;
  assign fault_W = fault_p1;

  generate
    if (TRACE) begin : g_trace
      always @(posedge clk) begin
        if (we) $display("@%h: *%h <= %h", PC_M, {AO_M[31:2], 2'b00}, merged);
      end
    end
  endgenerate

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver pushes hand-computed
// MEM/WB expectations, a monitor pops and compares one entry per cycle.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst_M, PC_M, AO_M, RT_M;
  logic [31:0] Inst_W, PC_W, AO_W, MO_W;
  logic        fault_W;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] ao;
    logic [31:0] mo;
    logic        fault;
    string       tag;
  } exp_t;

  exp_t q[$];
  logic [31:0] pc_cnt = 32'h0000_3000;

  memory_stage #(.ADDR_WIDTH(12), .TRACE(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .Inst_M  (Inst_M),
    .PC_M    (PC_M),
    .AO_M    (AO_M),
    .RT_M    (RT_M),
    .Inst_W  (Inst_W),
    .PC_W    (PC_W),
    .AO_W    (AO_W),
    .MO_W    (MO_W),
    .fault_W (fault_W)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SR  = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 5'd4, 5'd9, 16'h0010};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of MEM inputs and queue what WB must show after the edge.
  task automatic issue(input string tag, input logic rst, input logic [31:0] inst,
                       input logic [31:0] ao, input logic [31:0] rt,
                       input logic [31:0] mo, input logic flt);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    Inst_M = inst;
    PC_M   = pc_cnt;
    AO_M   = ao;
    RT_M   = rt;
    e.tag   = tag;
    e.inst  = rst ? 32'h0 : inst;
    e.pc    = rst ? 32'h0 : pc_cnt;
    e.ao    = rst ? 32'h0 : ao;
    e.mo    = rst ? 32'h0 : mo;
    e.fault = rst ? 1'b0 : flt;
    q.push_back(e);
    pc_cnt += 4;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".inst"},  Inst_W, e.inst);
        chk({e.tag, ".pc"},    PC_W,   e.pc);
        chk({e.tag, ".ao"},    AO_W,   e.ao);
        chk({e.tag, ".mo"},    MO_W,   e.mo);
        chk({e.tag, ".fault"}, {31'h0, fault_W}, {31'h0, e.fault});
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    reset  = 1'b1;
    Inst_M = 32'h0;
    PC_M   = 32'h0;
    AO_M   = 32'h0;
    RT_M   = 32'h0;
    @(negedge clk);

    issue("rst0", 1'b1, mk(OP_LW), 32'h10, 32'h0, 32'h0, 1'b0);
    issue("rst1", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    issue("sw10",   1'b0, mk(OP_SW),  32'h10, 32'h1234_5678, 32'h0,          1'b0);
    issue("lw10a",  1'b0, mk(OP_LW),  32'h10, 32'h0,         32'h1234_5678,  1'b0);
    issue("sb13",   1'b0, mk(OP_SB),  32'h13, 32'h0000_00AB, 32'h0,          1'b0);
    issue("lw10b",  1'b0, mk(OP_LW),  32'h10, 32'h0,         32'hAB34_5678,  1'b0);
    issue("lbu13",  1'b0, mk(OP_LBU), 32'h13, 32'h0,         32'h0000_00AB,  1'b0);
    issue("sh12",   1'b0, mk(OP_SH),  32'h12, 32'h0000_BEEF, 32'h0,          1'b0);
    issue("lh12",   1'b0, mk(OP_LH),  32'h12, 32'h0,         32'h0000_BEEF,  1'b0);
    issue("lw10c",  1'b0, mk(OP_LW),  32'h10, 32'h0,         32'hBEEF_5678,  1'b0);

    issue("sh11",   1'b0, mk(OP_SH),  32'h11, 32'h0000_1111, 32'h0,          1'b1);
    issue("lw12",   1'b0, mk(OP_LW),  32'h12, 32'h0,         32'h0,          1'b1);
    issue("lw10d",  1'b0, mk(OP_LW),  32'h10, 32'h0,         32'hBEEF_5678,  1'b0);

    issue("swfar",  1'b0, mk(OP_SW),  32'h0001_0000, 32'hDEAD_BEEF, 32'h0,   1'b1);
    issue("lw00",   1'b0, mk(OP_LW),  32'h0,         32'h0,         32'h0,   1'b0);
    issue("lwfar",  1'b0, mk(OP_LW),  32'h0001_0000, 32'h0,         32'h0,   1'b1);
    issue("srsv",   1'b0, mk(OP_SR),  32'h10, 32'h5555_5555, 32'h0,          1'b1);
    issue("lw10e",  1'b0, mk(OP_LW),  32'h10, 32'h0,         32'hBEEF_5678,  1'b0);
    issue("nop",    1'b0, 32'h0,      32'h10, 32'h0,         32'h0,          1'b0);
    issue("sw20",   1'b0, mk(OP_SW),  32'h20, 32'h0BAD_F00D, 32'h0,          1'b0);
    issue("lw20a",  1'b0, mk(OP_LW),  32'h20, 32'h0,         32'h0BAD_F00D,  1'b0);

    issue("swrst",  1'b1, mk(OP_SW),  32'h24, 32'hCAFE_F00D, 32'h0,          1'b0);
    issue("lw24",   1'b0, mk(OP_LW),  32'h24, 32'h0,         32'h0,          1'b0);
    issue("lw20b",  1'b0, mk(OP_LW),  32'h20, 32'h0,         32'h0,          1'b0);
    issue("lw10f",  1'b0, mk(OP_LW),  32'h10, 32'h0,         32'h0,          1'b0);

    @(negedge clk);
    Inst_M = 32'h0;
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
